// File: rtl/lcg_stim_gen.sv
// lcg_stim_gen: LCG-driven stimulus source with valid/ready handshake, run count, seed reload and abort.
// Define LCG_STIM_SIG_EN to add a rotating-XOR run signature on sig_out.
module lcg_stim_gen #(
  parameter int          OUT_W        = 136,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] SEED_DEFAULT = 32'h8BE5_D6D5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [31:0]      seed_in,
  input  logic             start,
  input  logic [CNT_W-1:0] cycles_in,
  input  logic             abort,
  output logic [OUT_W-1:0] stim_flat,
  output logic             stim_valid,
  input  logic             stim_ready,
  output logic [CNT_W-1:0] vec_count,
  output logic             busy,
  output logic             done,
  output logic [31:0]      sig_out
);
  // state | meaning
  // IDLE  | no run active; seed_load and start accepted
  // RUN   | presenting vectors; stim_valid is high throughout
  // DONE  | run completed; done held until the next start or abort

  localparam int          LANES   = (OUT_W + 31) / 32;
  localparam logic [31:0] LCG_MUL = 32'h41C6_4E6D;
  localparam logic [31:0] LCG_INC = 32'h0000_3039;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_lcg;
  logic [OUT_W-1:0]   r_stim_flat;
  logic               r_stim_valid;
  logic [CNT_W-1:0]   r_vec_count;
  logic [CNT_W-1:0]   r_remaining;
  logic               r_done;

  logic               w_xfer;
  logic               w_ctrl_open;
  logic               w_start_go;
  logic [31:0]        w_lcg_base;
  logic [31:0]        w_chain;
  logic [32*LANES-1:0] w_lanes;
  logic [OUT_W-1:0]   w_next_vec;
  logic [31:0]        w_lcg_end;

  assign w_xfer      = r_stim_valid & stim_ready;
  assign w_ctrl_open = (r_state != S_RUN);
  assign w_start_go  = w_ctrl_open & start & ~abort;
  // A same-cycle seed_load feeds the first vector of the new run directly.
  assign w_lcg_base  = (w_ctrl_open && seed_load) ? seed_in : r_lcg;

  always_comb begin
    w_chain = w_lcg_base;
    w_lanes = '0;
    for (int k = 0; k < LANES; k++) begin
      w_chain = w_chain * LCG_MUL + LCG_INC;
      w_lanes[32*k +: 32] = w_chain;
    end
  end

  // The top lane always holds the full final LCG state, even when truncated in the vector.
  assign w_next_vec = w_lanes[OUT_W-1:0];
  assign w_lcg_end  = w_lanes[32*LANES-1 -: 32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nxt = S_RUN;
      S_RUN:          if (w_xfer && (r_remaining == '0)) w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
    if (abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lcg        <= SEED_DEFAULT;
      r_stim_flat  <= '0;
      r_stim_valid <= 1'b0;
      r_vec_count  <= '0;
      r_remaining  <= '0;
      r_done       <= 1'b0;
    end else if (abort) begin
      r_stim_valid <= 1'b0;
      r_done       <= 1'b0;
      if (w_xfer) r_vec_count <= r_vec_count + CNT_W'(1);
    end else if (w_ctrl_open) begin
      if (seed_load) r_lcg <= seed_in;
      if (start) begin
        r_remaining  <= cycles_in;
        r_vec_count  <= '0;
        r_done       <= 1'b0;
        r_stim_flat  <= w_next_vec;
        r_stim_valid <= 1'b1;
        r_lcg        <= w_lcg_end;
      end
    end else if (w_xfer) begin
      r_vec_count <= r_vec_count + CNT_W'(1);
      if (r_remaining == '0) begin
        r_stim_valid <= 1'b0;
        r_done       <= 1'b1;
      end else begin
        r_remaining <= r_remaining - CNT_W'(1);
        r_stim_flat <= w_next_vec;
        r_lcg       <= w_lcg_end;
      end
    end
  end

`ifdef LCG_STIM_SIG_EN
  logic [31:0]         r_sig;
  logic [31:0]         w_fold;
  logic [32*LANES-1:0] w_flat_ext;

  always_comb begin
    w_flat_ext = '0;
    w_flat_ext[OUT_W-1:0] = r_stim_flat;
    w_fold = '0;
    for (int k = 0; k < LANES; k++) w_fold = w_fold ^ w_flat_ext[32*k +: 32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_sig <= '0;
    else if (w_start_go) r_sig <= '0;
    else if (w_xfer)     r_sig <= {r_sig[30:0], r_sig[31]} ^ w_fold;
  end

  assign sig_out = r_sig;
`else
  assign sig_out = '0;
`endif

  assign stim_flat  = r_stim_flat;
  assign stim_valid = r_stim_valid;
  assign vec_count  = r_vec_count;
  assign busy       = (r_state == S_RUN);
  assign done       = r_done;

endmodule

// File: tb/tb_lcg_stim_gen.sv
// Self-checking bench for lcg_stim_gen: transaction-level LCG model compared every cycle,
// plus directed literal checks and a small-CNT_W instance for counter wrap.
module tb_lcg_stim_gen;
  localparam int          W        = 136;
  localparam int          NL       = 5;
  localparam logic [31:0] SEED_DEF = 32'h8BE5_D6D5;

  logic          clk;
  logic          rst_n;
  logic          d_seed_load, d_start, d_abort, d_ready;
  logic [31:0]   d_seed_in, d_cycles;
  logic [W-1:0]  d_flat;
  logic          d_valid, d_busy, d_done;
  logic [31:0]   d_count, d_sig;

  logic          s_seed_load, s_start, s_abort, s_ready;
  logic [31:0]   s_seed_in;
  logic [2:0]    s_cycles, s_count;
  logic [19:0]   s_flat;
  logic          s_valid, s_busy, s_done;
  logic [31:0]   s_sig;

  int n_checks = 0;
  int n_err    = 0;

  lcg_stim_gen u_dut (
    .clk(clk), .rst_n(rst_n), .seed_load(d_seed_load), .seed_in(d_seed_in),
    .start(d_start), .cycles_in(d_cycles), .abort(d_abort), .stim_flat(d_flat),
    .stim_valid(d_valid), .stim_ready(d_ready), .vec_count(d_count),
    .busy(d_busy), .done(d_done), .sig_out(d_sig)
  );

  lcg_stim_gen #(.OUT_W(20), .CNT_W(3)) u_small (
    .clk(clk), .rst_n(rst_n), .seed_load(s_seed_load), .seed_in(s_seed_in),
    .start(s_start), .cycles_in(s_cycles), .abort(s_abort), .stim_flat(s_flat),
    .stim_valid(s_valid), .stim_ready(s_ready), .vec_count(s_count),
    .busy(s_busy), .done(s_done), .sig_out(s_sig)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lcg_step(input logic [31:0] s);
    return s * 32'h41C6_4E6D + 32'h0000_3039;
  endfunction

  function automatic logic [31:0] lcg_adv(input logic [31:0] s, input int n);
    logic [31:0] x = s;
    for (int i = 0; i < n; i++) x = lcg_step(x);
    return x;
  endfunction

  function automatic logic [W-1:0] gen_vec(input logic [31:0] s);
    logic [32*NL-1:0] w = '0;
    logic [31:0]      x = s;
    for (int k = 0; k < NL; k++) begin
      x = lcg_step(x);
      w[32*k +: 32] = x;
    end
    return w[W-1:0];
  endfunction

  function automatic logic [31:0] sig_step(input logic [31:0] sg, input logic [W-1:0] v);
`ifdef LCG_STIM_SIG_EN
    logic [32*NL-1:0] e = '0;
    logic [31:0]      f = '0;
    e[W-1:0] = v;
    for (int k = 0; k < NL; k++) f = f ^ e[32*k +: 32];
    return {sg[30:0], sg[31]} ^ f;
`else
    return sg & 32'h0;
`endif
  endfunction

  function automatic logic [31:0] sig_of(input logic [31:0] seed, input int nvec);
    logic [31:0] sg = '0;
    logic [31:0] x  = seed;
    for (int i = 0; i < nvec; i++) begin
      sg = sig_step(sg, gen_vec(x));
      x  = lcg_adv(x, NL);
    end
    return sg;
  endfunction

  // Transaction-level model: a run is a count of vectors still owed, each drawn from NL LCG steps.
  logic [W-1:0] m_vec;
  logic         m_valid, m_done;
  logic [31:0]  m_cnt, m_lcg, m_sig;
  logic [63:0]  m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vec <= '0; m_valid <= 1'b0; m_done <= 1'b0; m_cnt <= '0;
      m_lcg <= SEED_DEF; m_sig <= '0; m_left <= '0;
    end else begin
      if (m_valid && d_ready) begin
        m_cnt <= m_cnt + 32'd1;
        m_sig <= sig_step(m_sig, m_vec);
      end
      if (d_abort) begin
        m_valid <= 1'b0;
        m_done  <= 1'b0;
      end else if (!m_valid) begin
        if (d_start) begin
          m_vec   <= gen_vec(d_seed_load ? d_seed_in : m_lcg);
          m_lcg   <= lcg_adv(d_seed_load ? d_seed_in : m_lcg, NL);
          m_left  <= {32'd0, d_cycles} + 64'd1;
          m_cnt   <= '0;
          m_done  <= 1'b0;
          m_valid <= 1'b1;
          m_sig   <= '0;
        end else if (d_seed_load) begin
          m_lcg <= d_seed_in;
        end
      end else if (d_ready) begin
        if (m_left == 64'd1) begin
          m_valid <= 1'b0;
          m_done  <= 1'b1;
        end else begin
          m_left <= m_left - 64'd1;
          m_vec  <= gen_vec(m_lcg);
          m_lcg  <= lcg_adv(m_lcg, NL);
        end
      end
    end
  end

  logic [W-1:0] p_flat;
  logic         p_valid = 1'b0;
  int           xfer_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (p_valid && d_ready) xfer_cnt++;
      if (p_valid && !d_ready && !d_abort) chk("stall_hold", d_flat, p_flat);
      chk("cyc_valid", W'(d_valid), W'(m_valid));
      chk("cyc_busy",  W'(d_busy),  W'(m_valid));
      chk("cyc_done",  W'(d_done),  W'(m_done));
      chk("cyc_count", W'(d_count), W'(m_cnt));
      chk("cyc_flat",  d_flat,      m_vec);
      chk("cyc_sig",   W'(d_sig),   W'(m_sig));
      p_valid = d_valid;
      p_flat  = d_flat;
    end else begin
      p_valid = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic sl, input logic [31:0] sd, input logic [31:0] cyc);
    d_seed_load = sl; d_seed_in = sd; d_cycles = cyc; d_start = 1'b1;
    tick();
    d_seed_load = 1'b0; d_start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && d_busy; k++) tick();
    chk("run_finished", W'(d_busy), W'(1'b0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] vtmp;
    logic [31:0]  seed, sig_a, sig_exp;
    int           n, x0;

    rst_n = 1'b0;
    d_seed_load = 0; d_start = 0; d_abort = 0; d_ready = 0; d_seed_in = 0; d_cycles = 0;
    s_seed_load = 0; s_start = 0; s_abort = 0; s_ready = 0; s_seed_in = 0; s_cycles = 0;
    repeat (2) tick();
    chk("rst_valid", W'(d_valid), W'(1'b0));
    chk("rst_flat",  d_flat, '0);
    chk("rst_count", W'(d_count), '0);
    chk("rst_done",  W'(d_done), W'(1'b0));
    chk("rst_busy",  W'(d_busy), W'(1'b0));
    chk("rst_sig",   W'(d_sig), '0);
    rst_n = 1'b1;
    tick();

    // Seed 0, single vector.
    vtmp = gen_vec(32'h0);
    chk("model_pin_seed0", W'(vtmp[63:0]), W'(64'hD3DC167E_00003039));
    d_ready = 1'b1;
    do_start(1'b1, 32'h0, 32'd0);
    chk("seed0_vec_lo64", W'(d_flat[63:0]), W'(64'hD3DC167E_00003039));
    tick();
    chk("seed0_done",  W'(d_done),  W'(1'b1));
    chk("seed0_count", W'(d_count), W'(32'd1));
    chk("seed0_valid", W'(d_valid), W'(1'b0));

    // Seed 1, four vectors back to back.
    vtmp = gen_vec(32'h1);
    chk("model_pin_seed1", W'(vtmp[31:0]), W'(32'h41C67EA6));
    do_start(1'b1, 32'h1, 32'd3);
    chk("seed1_lane0", W'(d_flat[31:0]), W'(32'h41C67EA6));
    n = 0;
    for (int i = 0; i < 12 && d_valid; i++) begin n++; tick(); end
    chk("seed1_valid_cycles", W'(n), W'(4));
    chk("seed1_busy_low", W'(d_busy), W'(1'b0));
    chk("seed1_done_high", W'(d_done), W'(1'b1));

    // Stalled run: ready pattern 1,0,0,1,...
    d_ready = 1'b0;
    x0 = xfer_cnt;
    do_start(1'b1, $urandom, 32'd4);
    for (int k = 0; k < 60 && d_busy; k++) begin
      d_ready = (k % 3 == 0);
      tick();
    end
    chk("stall_run_ended", W'(d_busy), W'(1'b0));
    chk("stall_xfers", W'(xfer_cnt - x0), W'(5));
    chk("stall_count", W'(d_count), W'(32'd5));

    // Abort with three vectors still owed, then resume without reseed.
    d_ready = 1'b1;
    do_start(1'b0, 32'h0, 32'd6);
    repeat (4) tick();
    d_ready = 1'b0; d_abort = 1'b1;
    tick();
    d_abort = 1'b0;
    chk("abort_valid", W'(d_valid), W'(1'b0));
    chk("abort_busy",  W'(d_busy),  W'(1'b0));
    chk("abort_done",  W'(d_done),  W'(1'b0));
    chk("abort_count", W'(d_count), W'(32'd4));
    d_ready = 1'b1;
    do_start(1'b0, 32'h0, 32'd1);
    wait_idle();

    // Abort coinciding with a transfer still counts the transfer.
    do_start(1'b0, 32'h0, 32'd5);
    tick();
    d_abort = 1'b1;
    tick();
    d_abort = 1'b0;
    chk("abort_xfer_count", W'(d_count), W'(32'd2));
    chk("abort_xfer_valid", W'(d_valid), W'(1'b0));

    // Asynchronous reset mid-run.
    d_ready = 1'b0;
    do_start(1'b0, 32'h0, 32'd5);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", W'(d_valid), W'(1'b0));
    chk("midrst_flat",  d_flat, '0);
    chk("midrst_count", W'(d_count), '0);
    chk("midrst_busy",  W'(d_busy), W'(1'b0));
    chk("midrst_done",  W'(d_done), W'(1'b0));
    tick();
    rst_n = 1'b1;
    tick();
    d_ready = 1'b1;
    do_start(1'b0, 32'h0, 32'd2);
    vtmp = gen_vec(SEED_DEF);
    chk("post_reset_stream", d_flat, vtmp);
    wait_idle();

    // Randomised runs with ignored seed_load/start noise during RUN and sporadic aborts.
    for (int r = 0; r < 14; r++) begin
      d_ready = 1'($urandom % 2);
      do_start(1'($urandom % 2), $urandom, 32'($urandom_range(0, 5)));
      for (int k = 0; k < 80 && d_busy; k++) begin
        d_ready     = 1'($urandom % 2);
        d_abort     = ($urandom % 25 == 0);
        d_seed_load = 1'($urandom % 2);
        d_start     = 1'($urandom % 2);
        d_seed_in   = $urandom;
        tick();
      end
      d_abort = 0; d_seed_load = 0; d_start = 0;
      chk("rand_run_ended", W'(d_busy), W'(1'b0));
      tick();
    end

    // Signature: repeatable for a fixed seed, sensitive to one seed bit.
    d_ready = 1'b1;
    seed = $urandom;
    sig_exp = sig_of(seed, 4);
    do_start(1'b1, seed, 32'd3);
    wait_idle();
    chk("sig_run_a", W'(d_sig), W'(sig_exp));
    sig_a = d_sig;
    do_start(1'b1, seed, 32'd3);
    wait_idle();
    chk("sig_run_b", W'(d_sig), W'(sig_exp));
    do_start(1'b1, seed ^ 32'h1, 32'd3);
    wait_idle();
    chk("sig_run_flip", W'(d_sig), W'(sig_of(seed ^ 32'h1, 4)));
`ifdef LCG_STIM_SIG_EN
    n_checks++;
    if (d_sig == sig_a) begin
      n_err++;
      $display("FAIL sig_differs actual=%h must differ from %h", d_sig, sig_a);
    end
`else
    chk("sig_zero", W'(d_sig | sig_a), '0);
`endif

    // Narrow counter: cycles_in all-ones gives 2^CNT_W vectors and vec_count wraps.
    s_ready = 1'b1; s_seed_load = 1'b1; s_seed_in = 32'h1; s_start = 1'b1; s_cycles = 3'd7;
    tick();
    s_seed_load = 1'b0; s_start = 1'b0;
    chk("small_first_vec", W'(s_flat), W'(20'h67EA6));
    n = 0;
    for (int i = 0; i < 20 && s_valid; i++) begin n++; tick(); end
    chk("small_vec_total", W'(n), W'(8));
    chk("small_count_wrap", W'(s_count), W'(3'd0));
    chk("small_done", W'(s_done), W'(1'b1));

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/lcg_stim_gen.md
Name: lcg_stim_gen

Overview:
Synthesizable, parametrised stimulus source for the fuzzing flow. It produces OUT_W-bit pseudo-random vectors from a 32-bit LCG (x' = x*32'h41C64E6D + 32'h3039 mod 2^32), filling the vector in 32-bit lanes, LSB lane first. It adds a valid/ready handshake, a programmable vector count, seed reload, and abort. It sits between the run controller and the DUT input bus, so bench and hardware runs replay bit-identical streams.

Parameters:
OUT_W, 136, stimulus vector width (>=1)
CNT_W, 32, width of the vector-count and counter fields
SEED_DEFAULT, 32'h8BE5_D6D5, LCG state after reset
LANES, (OUT_W+31)/32, derived; LCG steps per vector; not overridable

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
seed_load  in  1  load seed_in into LCG state (IDLE/DONE only)
seed_in  in  32  seed value
start  in  1  begin a run (IDLE/DONE only)
cycles_in  in  CNT_W  vectors after the first; run emits cycles_in+1 vectors
abort  in  1  terminate run, return to IDLE
stim_flat  out  OUT_W  current vector
stim_valid  out  1  stim_flat is valid
stim_ready  in  1  consumer accepts vector
vec_count  out  CNT_W  vectors accepted in current run
busy  out  1  state==RUN
done  out  1  run completed (sticky)
sig_out  out  32  signature (optional feature)

Behaviour:
- Reset, asynchronous, active-low: state=IDLE, lcg=SEED_DEFAULT, stim_flat=0, stim_valid=0, vec_count=0, remaining=0, done=0, sig_out=0.
- Vector generation (next_vec): for lane k=0..LANES-1, lcg steps once; lane k takes the new lcg value. Lane k maps to bits [32k+31:32k]. The last lane is truncated to its low OUT_W-32*(LANES-1) bits. lcg advances by exactly LANES steps per vector. All steps are chained combinationally in one cycle.
- States: IDLE, RUN, DONE.
- IDLE/DONE:
  - seed_load=1: lcg<=seed_in.
  - start=1 (seed_load=0): remaining<=cycles_in; vec_count<=0; done<=0; stim_flat<=next_vec; stim_valid<=1; go to RUN. Latency start->stim_valid is 1 cycle.
  - seed_load and start in the same cycle: the seed is loaded, then the first vector is generated from seed_in in that cycle.
- RUN, handshake:
  - A transfer occurs when stim_valid&&stim_ready.
  - While stim_valid&&!stim_ready, stim_flat and lcg hold.
  - On transfer, vec_count increments.
  - If remaining==0: stim_valid<=0, done<=1, go to DONE.
  - Else: remaining decrements, stim_flat<=next_vec, stim_valid stays 1. A back-to-back vector is issued every cycle while ready=1.
  - seed_load and start are ignored in RUN.
- abort (any state, highest priority after reset): stim_valid<=0, done<=0, go to IDLE. lcg, vec_count and stim_flat retain their values. Abort in the same cycle as a transfer: the transfer still counts (vec_count increments), then the block goes to IDLE.
- cycles_in=0: exactly one vector is emitted.
- cycles_in=all-ones: remaining counts down without wrap; the run emits 2^CNT_W vectors. vec_count wraps mod 2^CNT_W.
- Reset mid-run: immediate return to reset values; stim_valid drops asynchronously.

Optional Feature:
LCG_STIM_SIG_EN
- Defined: on every transfer, sig <= {sig[30:0],sig[31]} ^ fold32(stim_flat), where fold32 is the XOR of all 32-bit lanes (last lane zero-extended). sig clears on start; sig_out=sig. Used to compare runs across simulators with one word.
- Undefined: no signature register; sig_out tied to 0.

Test Plan:
- Reset, then seed_load seed_in=0, start cycles_in=0, OUT_W=64, ready=1 -> one vector stim_flat=64'hD3DC167E_00003039; done=1 one cycle after the transfer; vec_count=1.
- seed 1, OUT_W=32, cycles_in=3, ready=1 -> first vector 32'h41C67EA6; 4 consecutive valid cycles; busy deasserts with done rising.
- Default OUT_W=136, cycles_in=4, ready toggling 1,0,0,1,... -> stim_flat is stable across every stall; exactly 5 transfers; top 128 bits are zero-free per lanes; bits above 135 do not exist.
- Abort while 3 vectors remain -> stim_valid=0 next cycle, state IDLE, done=0; a following start resumes the LCG sequence from the retained lcg (no reseed).
- Assert rst_n low mid-run -> all outputs return to reset values immediately; start after reset reproduces the SEED_DEFAULT stream.
- With LCG_STIM_SIG_EN, the same seed and count run twice -> identical sig_out; one flipped seed bit -> different sig_out. Without the macro, sig_out=0 throughout.
